// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
//
// Shares one single-port data RAM between the core's MEM stage (CPU port)
// and a DMA/loader port. At most one port is granted per cycle; the granted
// port drives the RAM directly, and read data is registered into the owning
// port one cycle later. The CPU normally has priority, but a starvation
// counter forces a DMA grant after STARVE_MAX unserved DMA request cycles,
// and dma_lock lets the DMA keep ownership for an uninterrupted burst.
//
// Ports:
//   CLK, RSTa                 clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata     CPU access request (held until granted)
//   dma_req/we/addr/wdata     DMA access request (held until granted)
//   dma_lock                  keep DMA ownership after the current grant
//   cpu_gnt, dma_gnt          access performed this cycle (combinational)
//   cpu_rvalid/rdata          registered CPU read return (one-cycle pulse)
//   dma_rvalid/rdata          registered DMA read return (one-cycle pulse)
//   mem_addr/write/wdata      RAM controls
//   mem_rdata                 RAM combinational read data
// ---------------------------------------------------------------------------
module data_mem_arbiter #(
    parameter int size       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            CLK,
    input  logic            RSTa,
    input  logic            cpu_req,
    input  logic            cpu_we,
    input  logic [31:0]     cpu_addr,
    input  logic [size-1:0] cpu_wdata,
    input  logic            dma_req,
    input  logic            dma_we,
    input  logic [31:0]     dma_addr,
    input  logic [size-1:0] dma_wdata,
    input  logic            dma_lock,
    output logic            cpu_gnt,
    output logic            dma_gnt,
    output logic            cpu_rvalid,
    output logic            dma_rvalid,
    output logic [size-1:0] cpu_rdata,
    output logic [size-1:0] dma_rdata,
    output logic [31:0]     mem_addr,
    output logic            mem_write,
    output logic [size-1:0] mem_wdata,
    input  logic [size-1:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    typedef enum logic {
        CPU_PRI  = 1'b0,
        DMA_LOCK = 1'b1
    } state_t;

    state_t        state, state_next;
    logic [SW-1:0] starve, starve_next;

    // Grant decision. Reset gates both grants so that nothing reaches the
    // RAM, and nothing is captured, while RSTa is high.
    always_comb begin
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        if (!RSTa) begin
            case (state)
                CPU_PRI: begin
                    if (dma_req && (starve == STARVE_TOP)) begin
                        dma_gnt = 1'b1;
                    end else if (cpu_req) begin
                        cpu_gnt = 1'b1;
                    end else if (dma_req) begin
                        dma_gnt = 1'b1;
                    end
                end
                DMA_LOCK: begin
                    dma_gnt = dma_req;
                end
                default: begin
                    cpu_gnt = 1'b0;
                    dma_gnt = 1'b0;
                end
            endcase
        end
    end

    // RAM drive: the granted port passes straight through; an idle cycle
    // parks the bus at zero with the write enable low.
    always_comb begin
        mem_addr  = '0;
        mem_write = 1'b0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_write = cpu_we;
            mem_wdata = cpu_wdata;
        end else if (dma_gnt) begin
            mem_addr  = dma_addr;
            mem_write = dma_we;
            mem_wdata = dma_wdata;
        end
    end

    // Next state and starvation count. Dropping dma_lock is seen in the
    // same cycle, but that cycle remains DMA-owned; the CPU regains
    // priority from the following cycle.
    always_comb begin
        state_next  = state;
        starve_next = starve;

        if (dma_gnt || !dma_req) begin
            starve_next = '0;
        end else if (starve != STARVE_TOP) begin
            starve_next = starve + 1'b1;
        end

        case (state)
            CPU_PRI: begin
                if (dma_gnt && dma_lock) begin
                    state_next = DMA_LOCK;
                end
            end
            DMA_LOCK: begin
                if (!dma_lock) begin
                    state_next = CPU_PRI;
                end
            end
            default: begin
                state_next = CPU_PRI;
            end
        endcase
    end

    // State register and read-return capture. rdata only changes on a
    // granted read of its own port, so it holds between reads.
    always_ff @(posedge CLK or posedge RSTa) begin
        if (RSTa) begin
            state      <= CPU_PRI;
            starve     <= '0;
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dma_rdata  <= '0;
        end else begin
            state      <= state_next;
            starve     <= starve_next;
            cpu_rvalid <= cpu_gnt && !cpu_we;
            dma_rvalid <= dma_gnt && !dma_we;
            if (cpu_gnt && !cpu_we) begin
                cpu_rdata <= mem_rdata;
            end
            if (dma_gnt && !dma_we) begin
                dma_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_mem_arbiter
//
// Directed bench for data_mem_arbiter with a behavioural RAM attached.
// Expected read data comes from a bench-side memory image and is queued per
// port when a read grant is expected, then popped when rvalid is due.
// ---------------------------------------------------------------------------
module tb_data_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RSTa;
    logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid;
    logic [31:0] cpu_rdata, dma_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write;

    logic [31:0] ram       [0:1023];
    logic [31:0] model_mem [0:1023];
    logic [31:0] cpu_q [$];
    logic [31:0] dma_q [$];
    logic [31:0] exp_cpu_rdata, exp_dma_rdata;

    int checks   = 0;
    int failures = 0;

    data_mem_arbiter #(.size(32), .STARVE_MAX(4)) dut (
        .CLK        (CLK),
        .RSTa       (RSTa),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_lock   (dma_lock),
        .cpu_gnt    (cpu_gnt),
        .dma_gnt    (dma_gnt),
        .cpu_rvalid (cpu_rvalid),
        .dma_rvalid (dma_rvalid),
        .cpu_rdata  (cpu_rdata),
        .dma_rdata  (dma_rdata),
        .mem_addr   (mem_addr),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 CLK = ~CLK;

    // Behavioural single-port RAM: combinational read, write at the edge.
    assign mem_rdata = ram[mem_addr[11:2]];
    always @(posedge CLK) begin
        if (mem_write) ram[mem_addr[11:2]] <= mem_wdata;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive the inputs just after the edge, let the
    // combinational grant settle, then check it along with the read return
    // caused by the previous cycle.
    task automatic applyStimulus(
        input string       tag,
        input logic        c_req, input logic c_we, input logic [31:0] c_addr, input logic [31:0] c_wd,
        input logic        d_req, input logic d_we, input logic [31:0] d_addr, input logic [31:0] d_wd,
        input logic        d_lock,
        input logic        exp_cg, input logic exp_dg
    );
        logic        exp_rv;
        logic [31:0] exp_maddr, exp_mwd;
        logic        exp_mwe;
        @(posedge CLK);
        #1;
        cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wd;
        dma_req = d_req; dma_we = d_we; dma_addr = d_addr; dma_wdata = d_wd;
        dma_lock = d_lock;
        #1;

        exp_rv = (cpu_q.size() != 0);
        checkOutput({tag, " cpu_rvalid"}, {31'b0, cpu_rvalid}, {31'b0, exp_rv});
        if (exp_rv) exp_cpu_rdata = cpu_q.pop_front();
        checkOutput({tag, " cpu_rdata"}, cpu_rdata, exp_cpu_rdata);

        exp_rv = (dma_q.size() != 0);
        checkOutput({tag, " dma_rvalid"}, {31'b0, dma_rvalid}, {31'b0, exp_rv});
        if (exp_rv) exp_dma_rdata = dma_q.pop_front();
        checkOutput({tag, " dma_rdata"}, dma_rdata, exp_dma_rdata);

        checkOutput({tag, " cpu_gnt"}, {31'b0, cpu_gnt}, {31'b0, exp_cg});
        checkOutput({tag, " dma_gnt"}, {31'b0, dma_gnt}, {31'b0, exp_dg});

        exp_maddr = exp_cg ? c_addr : (exp_dg ? d_addr : 32'h0);
        exp_mwd   = exp_cg ? c_wd   : (exp_dg ? d_wd   : 32'h0);
        exp_mwe   = exp_cg ? c_we   : (exp_dg ? d_we   : 1'b0);
        checkOutput({tag, " mem_addr"},  mem_addr, exp_maddr);
        checkOutput({tag, " mem_wdata"}, mem_wdata, exp_mwd);
        checkOutput({tag, " mem_write"}, {31'b0, mem_write}, {31'b0, exp_mwe});

        if (exp_cg) begin
            if (c_we) model_mem[c_addr[11:2]] = c_wd;
            else      cpu_q.push_back(model_mem[c_addr[11:2]]);
        end
        if (exp_dg) begin
            if (d_we) model_mem[d_addr[11:2]] = d_wd;
            else      dma_q.push_back(model_mem[d_addr[11:2]]);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i]       = 32'h0;
            model_mem[i] = 32'h0;
        end
        exp_cpu_rdata = 32'h0;
        exp_dma_rdata = 32'h0;

        // Reset held with both ports requesting
        RSTa = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;   cpu_wdata = 32'h0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h200; dma_wdata = 32'h0;
        dma_lock = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        checkOutput("reset cpu_gnt",    {31'b0, cpu_gnt},    32'h0);
        checkOutput("reset dma_gnt",    {31'b0, dma_gnt},    32'h0);
        checkOutput("reset mem_write",  {31'b0, mem_write},  32'h0);
        checkOutput("reset cpu_rvalid", {31'b0, cpu_rvalid}, 32'h0);
        checkOutput("reset dma_rvalid", {31'b0, dma_rvalid}, 32'h0);
        checkOutput("reset cpu_rdata",  cpu_rdata,           32'h0);
        checkOutput("reset dma_rdata",  dma_rdata,           32'h0);
        cpu_req = 1'b0; dma_req = 1'b0;
        @(negedge CLK);
        RSTa = 1'b0;

        // First cycle after reset: both request, CPU wins
        applyStimulus("first",  1, 0, 32'h0,  32'h0,        1, 0, 32'h200, 32'h0, 0, 1, 0);

        // CPU write then read-back of the same word
        applyStimulus("cwr",    1, 1, 32'h40, 32'hDEADBEEF, 0, 0, 32'h0,   32'h0, 0, 1, 0);
        applyStimulus("crd",    1, 0, 32'h40, 32'h0,        0, 0, 32'h0,   32'h0, 0, 1, 0);
        applyStimulus("crd_ret",0, 0, 32'h0,  32'h0,        0, 0, 32'h0,   32'h0, 0, 0, 0);

        // Starvation: CPU wins four cycles, DMA forced on the fifth
        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("starve%0d", i), 1, 1, 32'h80 + 32'(4 * i), 32'h1111_0000 + 32'(i),
                          1, 1, 32'h300, 32'hA5A5_0000, 0, 1, 0);
        end
        applyStimulus("forced", 1, 1, 32'h90,  32'h2222_0000, 1, 1, 32'h300, 32'hA5A5_0000, 0, 0, 1);
        applyStimulus("after",  1, 0, 32'h300, 32'h0,        1, 0, 32'h84,  32'h0,        0, 1, 0);
        applyStimulus("drd",    0, 0, 32'h0,   32'h0,        1, 0, 32'h84,  32'h0,        0, 0, 1);
        applyStimulus("drd_ret",0, 0, 32'h0,   32'h0,        0, 0, 32'h0,   32'h0,        0, 0, 0);

        // Locked DMA burst with the CPU waiting
        applyStimulus("lock0",  0, 1, 32'h44, 32'h4444_4444, 1, 1, 32'h100, 32'hB000_0100, 1, 0, 1);
        applyStimulus("lock1",  1, 1, 32'h44, 32'h4444_4444, 1, 1, 32'h104, 32'hB000_0104, 1, 0, 1);
        applyStimulus("lock2",  1, 1, 32'h44, 32'h4444_4444, 1, 1, 32'h108, 32'hB000_0108, 0, 0, 1);
        applyStimulus("unlock", 1, 1, 32'h44, 32'h4444_4444, 0, 0, 32'h0,   32'h0,        0, 1, 0);

        // Lock held with no DMA request idles the RAM
        applyStimulus("lkrd",   0, 0, 32'h0,   32'h0,        1, 0, 32'h104, 32'h0, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus($sformatf("idle%0d", i), 1, 1, 32'h48, 32'h5555_5555,
                          0, 0, 32'h0, 32'h0, 1, 0, 0);
        end
        applyStimulus("rel",    1, 1, 32'h48,  32'h5555_5555, 0, 0, 32'h0, 32'h0, 0, 0, 0);
        applyStimulus("relcpu", 1, 0, 32'h108, 32'h0,         0, 0, 32'h0, 32'h0, 0, 1, 0);
        applyStimulus("rel_ret",0, 0, 32'h0,   32'h0,         0, 0, 32'h0, 32'h0, 0, 0, 0);

        // Reset during a granted, locking DMA read aborts it
        applyStimulus("rstrd",  0, 0, 32'h0,   32'h0,        1, 0, 32'h100, 32'h0, 1, 0, 1);
        #1;
        RSTa = 1'b1;
        cpu_req = 1'b0; dma_req = 1'b0; dma_lock = 1'b0;
        #1;
        checkOutput("midrst dma_gnt", {31'b0, dma_gnt}, 32'h0);
        dma_q.delete();
        cpu_q.delete();
        exp_cpu_rdata = 32'h0;
        exp_dma_rdata = 32'h0;
        @(posedge CLK);
        #1;
        RSTa = 1'b0;
        #1;
        checkOutput("midrst dma_rvalid", {31'b0, dma_rvalid}, 32'h0);
        checkOutput("midrst dma_rdata",  dma_rdata,           32'h0);

        // Back in CPU priority with a cleared starvation count
        applyStimulus("post",   1, 0, 32'h44, 32'h0, 1, 0, 32'h104, 32'h0, 0, 1, 0);
        applyStimulus("post_d", 0, 0, 32'h0,  32'h0, 1, 0, 32'h104, 32'h0, 0, 0, 1);
        applyStimulus("post_r", 0, 0, 32'h0,  32'h0, 0, 0, 32'h0,   32'h0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
